// File: rtl/bram_s4_port_arbiter_pkg.sv
// ============================================================================
// Module  : bram_arb_pkg
// Brief   : Shared widths, FSM state type and helpers for the BRAM port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4096;

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    ARB   = 1'b1
  } state_t;

  typedef logic [1:0] req_id_t;

  function automatic req_id_t next_ptr(input req_id_t cur, input int n);
    if (int'(cur) >= n - 1) return '0;
    return cur + req_id_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_s4_port_arbiter_if.sv
// ============================================================================
// Module  : bram_s4_port_arbiter_if
// Brief   : Client request bus plus RAM port pins of the BRAM port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_s4_port_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_di;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_di;
  logic                      ram_ssr;
  logic [DATA_W-1:0]         ram_do;

  modport master (
    output req, req_we, req_addr, req_di, ram_do,
    input  gnt, rvalid, rdata, busy, ram_en, ram_we, ram_addr, ram_di, ram_ssr
  );

  modport slave (
    input  req, req_we, req_addr, req_di, ram_do,
    output gnt, rvalid, rdata, busy, ram_en, ram_we, ram_addr, ram_di, ram_ssr
  );

endinterface

`default_nettype wire

// File: rtl/bram_s4_port_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first request at or above the
//           pointer, wrapping; one-hot grant plus encoded winner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  req_id_t            i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output req_id_t            o_winner,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_pos;

  // Rotate so the pointer position lands at bit 0; the lowest set bit wins.
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        w_pos   = int'(i_ptr) + k;
      end
    end
    if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
    o_winner = req_id_t'(w_pos);
    for (int j = 0; j < NUM_REQ; j++) begin
      o_gnt[j] = o_valid && (w_pos == j);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_s4_port_arbiter.sv
// ============================================================================
// Module  : bram_s4_port_arbiter
// Brief   : Round-robin sharing of one 4096x4 BRAM port, 2-cycle read return.
//           Define BRAM_ARB_SCRUB_EN to fill the RAM with SCRUB_VAL after reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_s4_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int                NUM_REQ   = 2,
  parameter logic [DATA_W-1:0] SCRUB_VAL = 4'h0
) (
  input logic                   clk,
  input logic                   rst,
  bram_s4_port_arbiter_if.slave bus
);

  state_t              r_state;
  req_id_t             r_ptr;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_di;
  logic                r_p1_vld;
  logic                r_p2_vld;
  req_id_t             r_p1_id;
  req_id_t             r_p2_id;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  req_id_t             w_winner;
  logic                w_any;
  logic                w_take;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_di;

`ifdef BRAM_ARB_SCRUB_EN
  logic [ADDR_W-1:0]   r_scrub_cnt;
  localparam state_t   c_rst_state = SCRUB;
`else
  localparam state_t   c_rst_state = ARB;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_gnt    (w_pick_gnt),
    .o_winner (w_winner),
    .o_valid  (w_any)
  );

  assign w_take   = (r_state == ARB) && w_any;
  assign bus.gnt  = w_take ? w_pick_gnt : '0;
  assign w_sel_we = |(bus.req_we & w_pick_gnt);

  always_comb begin
    w_sel_addr = '0;
    w_sel_di   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_di   = bus.req_di[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rvalid[i] = r_p2_vld && (int'(r_p2_id) == i);
    end
  end

  assign bus.rdata    = bus.ram_do;
  assign bus.ram_en   = r_ram_en;
  assign bus.ram_we   = r_ram_we;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_di   = r_ram_di;
  assign bus.ram_ssr  = 1'b0;

`ifdef BRAM_ARB_SCRUB_EN
  assign bus.busy = (r_state != ARB);
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_rst_state;
      r_ptr      <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_di   <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_id    <= '0;
      r_p2_vld   <= 1'b0;
      r_p2_id    <= '0;
`ifdef BRAM_ARB_SCRUB_EN
      r_scrub_cnt <= '0;
`endif
    end else begin
      // Read return pipe: stage 1 loads with the grant, stage 2 meets RAM_DO.
      r_p2_vld <= r_p1_vld;
      r_p2_id  <= r_p1_id;
      if (r_state == SCRUB) begin
        r_p1_vld <= 1'b0;
`ifdef BRAM_ARB_SCRUB_EN
        r_ram_en    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= r_scrub_cnt;
        r_ram_di    <= SCRUB_VAL;
        r_scrub_cnt <= r_scrub_cnt + 1'b1;
        if (r_scrub_cnt == ADDR_W'(DEPTH - 1)) r_state <= ARB;
`else
        r_state <= ARB;
`endif
      end else if (w_any) begin
        r_ram_en   <= 1'b1;
        r_ram_we   <= w_sel_we;
        r_ram_addr <= w_sel_addr;
        r_ram_di   <= w_sel_di;
        r_ptr      <= next_ptr(w_winner, NUM_REQ);
        r_p1_vld   <= ~w_sel_we;
        r_p1_id    <= w_winner;
      end else begin
        r_ram_en <= 1'b0;
        r_ram_we <= 1'b0;
        r_p1_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_s4_port_arbiter.sv
// ============================================================================
// Module  : tb_bram_s4_port_arbiter
// Brief   : Self-checking bench with a behavioural RAM, directed sequences,
//           a grant table and a randomized run against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_s4_port_arbiter;
  import bram_arb_pkg::*;

`ifdef BRAM_ARB_SCRUB_EN
  localparam bit c_scrub_on = 1'b1;
`else
  localparam bit c_scrub_on = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_s4_port_arbiter_if #(.NUM_REQ(2)) bus ();

  bram_s4_port_arbiter #(
    .NUM_REQ   (2),
    .SCRUB_VAL (4'h3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port RAM behind the arbiter.
  logic [3:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
      else            bus.ram_do <= mem[bus.ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] we,
                       input logic [11:0] a0, input logic [11:0] a1,
                       input logic [3:0] d0, input logic [3:0] d1);
    bus.req      = rq;
    bus.req_we   = we;
    bus.req_addr = {a1, a0};
    bus.req_di   = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after reset release; returns at the negedge of the first idle ARB cycle.
  task automatic settle(input bit first);
    int n;
    int gnt_seen;
    n = 0;
    gnt_seen = 0;
`ifdef BRAM_ARB_SCRUB_EN
    if (first) drive(2'b01, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    while (bus.busy && n < 5000) begin
      if (bus.gnt != 2'b00) gnt_seen++;
      tick();
      if (n >= 100) drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
      n++;
      @(negedge clk);
    end
    chk("scrub_busy_cycles", n, 4096);
    if (first) chk("scrub_req_ignored", gnt_seen, 0);
`else
    @(negedge clk);
    chk("busy_after_release", {31'b0, bus.busy}, 0);
`endif
  endtask

  task automatic reset_and_settle();
    tick();
    rst = 1'b1;
    drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
    settle(1'b0);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
  } vec_t;
  vec_t tbl [11];

  // Reference model state for the randomized run.
  logic [1:0]  pend;
  logic [1:0]  pwe;
  logic [11:0] pa [2];
  logic [3:0]  pd [2];
  logic [3:0]  ref_mem [8];
  bit          ref_known [8];
  int          rv_id  [0:404];
  logic [3:0]  rv_dat [0:404];
  bit          rv_chk [0:404];

  initial begin
    int ptr, w, idx;
    logic        e_en, e_we;
    logic [11:0] e_addr;
    logic [3:0]  e_di;
    logic [11:0] sa [5];

    drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",      {30'b0, bus.gnt}, 0);
    chk("rst_rvalid",   {30'b0, bus.rvalid}, 0);
    chk("rst_ram_en",   {31'b0, bus.ram_en}, 0);
    chk("rst_ram_we",   {31'b0, bus.ram_we}, 0);
    chk("rst_ram_addr", {20'b0, bus.ram_addr}, 0);
    chk("rst_ram_di",   {28'b0, bus.ram_di}, 0);
    chk("rst_ram_ssr",  {31'b0, bus.ram_ssr}, 0);
    chk("rst_busy",     {31'b0, bus.busy}, {31'b0, c_scrub_on});
    tick();
    rst = 1'b0;
    settle(1'b1);

`ifdef BRAM_ARB_SCRUB_EN
    sa[0] = 12'd0; sa[1] = 12'd2048; sa[2] = 12'd4095; sa[3] = 12'd0; sa[4] = 12'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive((i < 3) ? 2'b01 : 2'b00, 2'b00, sa[i], 12'h0, 4'h0, 4'h0);
      @(negedge clk);
      if (i >= 2) begin
        chk("scrub_rd_valid", {30'b0, bus.rvalid}, 2'b01);
        chk("scrub_rd_data",  {28'b0, bus.rdata}, 4'h3);
      end
    end
    reset_and_settle();
`endif

    // First request after release, a write of 4'hA to address 5.
    tick();
    drive(2'b01, 2'b01, 12'h005, 12'h0, 4'hA, 4'h0);
    @(negedge clk);
    chk("first_req_gnt", {30'b0, bus.gnt}, 2'b01);
    tick();
    drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("wr_ram_en",   {31'b0, bus.ram_en}, 1);
    chk("wr_ram_we",   {31'b0, bus.ram_we}, 1);
    chk("wr_ram_addr", {20'b0, bus.ram_addr}, 12'h005);
    chk("wr_ram_di",   {28'b0, bus.ram_di}, 4'hA);

    // Single read: data returns exactly two cycles after the grant.
    tick();
    drive(2'b01, 2'b00, 12'h005, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("rd_gnt", {30'b0, bus.gnt}, 2'b01);
    tick();
    drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("rd_rvalid_n1", {30'b0, bus.rvalid}, 0);
    chk("rd_ram_we",    {31'b0, bus.ram_we}, 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid_n2", {30'b0, bus.rvalid}, 2'b01);
    chk("rd_rdata",     {28'b0, bus.rdata}, 4'hA);
    tick();
    @(negedge clk);
    chk("rd_rvalid_n3", {30'b0, bus.rvalid}, 0);

    // Grant sequence table from pointer 0.
    tbl[0]  = '{2'b11, 2'b01}; tbl[1]  = '{2'b11, 2'b10};
    tbl[2]  = '{2'b11, 2'b01}; tbl[3]  = '{2'b11, 2'b10};
    tbl[4]  = '{2'b10, 2'b10}; tbl[5]  = '{2'b10, 2'b10};
    tbl[6]  = '{2'b01, 2'b01}; tbl[7]  = '{2'b00, 2'b00};
    tbl[8]  = '{2'b11, 2'b10}; tbl[9]  = '{2'b01, 2'b01};
    tbl[10] = '{2'b11, 2'b10};
    reset_and_settle();
    for (int i = 0; i < 11; i++) begin
      tick();
      drive(tbl[i].req, 2'b00, 12'h010, 12'h011, 4'h0, 4'h0);
      @(negedge clk);
      chk($sformatf("tbl_gnt[%0d]", i), {30'b0, bus.gnt}, {30'b0, tbl[i].gnt});
    end

    // Write-then-read across requesters at the top address.
    reset_and_settle();
    tick();
    drive(2'b01, 2'b01, 12'hFFF, 12'h0, 4'h7, 4'h0);
    @(negedge clk);
    chk("wtr_gnt_w", {30'b0, bus.gnt}, 2'b01);
    tick();
    drive(2'b10, 2'b00, 12'h0, 12'hFFF, 4'h0, 4'h0);
    @(negedge clk);
    chk("wtr_gnt_r", {30'b0, bus.gnt}, 2'b10);
    tick();
    drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("wtr_rvalid_early", {30'b0, bus.rvalid}, 0);
    tick();
    @(negedge clk);
    chk("wtr_rvalid", {30'b0, bus.rvalid}, 2'b10);
    chk("wtr_rdata",  {28'b0, bus.rdata}, 4'h7);

    // Reset the cycle after a read grant: the read is dropped.
    tick();
    drive(2'b01, 2'b00, 12'h005, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("rmr_gnt", {30'b0, bus.gnt}, 2'b01);
    tick();
    drive(2'b00, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rmr_ram_en", {31'b0, bus.ram_en}, 0);
    for (int i = 0; i < 2; i++) begin
      chk("rmr_rvalid", {30'b0, bus.rvalid}, 0);
      tick();
      @(negedge clk);
    end
    tick();
    rst = 1'b0;
    settle(1'b0);
    chk("rmr_rvalid_after", {30'b0, bus.rvalid}, 0);
    chk("rmr_ram_en_after", {31'b0, bus.ram_en}, 0);
    tick();
    drive(2'b11, 2'b00, 12'h0, 12'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("rmr_ptr_zero", {30'b0, bus.gnt}, 2'b01);

    // Randomized traffic against the reference model.
    reset_and_settle();
    ptr = 0;
    pend = 2'b00;
    pwe = 2'b00;
    e_en = 1'b0;
    e_we = 1'b0;
    e_addr = c_scrub_on ? 12'hFFF : 12'h000;
    e_di   = c_scrub_on ? 4'h3 : 4'h0;
    for (int i = 0; i < 8; i++) begin
      ref_known[i] = 1'b0;
      ref_mem[i] = 4'h0;
    end
    for (int c = 0; c < 405; c++) begin
      rv_id[c] = -1;
      rv_chk[c] = 1'b0;
      rv_dat[c] = 4'h0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(1, 0) == 1) begin
          pend[r] = 1'b1;
          pwe[r]  = ($urandom_range(1, 0) == 1);
          pa[r]   = 12'($urandom_range(7, 0));
          pd[r]   = 4'($urandom_range(15, 0));
        end
      end
      drive(pend, pwe, pa[0], pa[1], pd[0], pd[1]);
      @(negedge clk);
      w = -1;
      for (int k = 0; k < 2; k++) begin
        idx = (ptr + k) % 2;
        if (w < 0 && pend[idx]) w = idx;
      end
      chk("rnd_gnt", {30'b0, bus.gnt}, (w < 0) ? 32'd0 : (32'd1 << w));
      chk("rnd_ram_en", {31'b0, bus.ram_en}, {31'b0, e_en});
      chk("rnd_ram_we", {31'b0, bus.ram_we}, {31'b0, e_we});
      chk("rnd_ram_addr", {20'b0, bus.ram_addr}, {20'b0, e_addr});
      chk("rnd_ram_di", {28'b0, bus.ram_di}, {28'b0, e_di});
      chk("rnd_rvalid", {30'b0, bus.rvalid}, (rv_id[cyc] < 0) ? 32'd0 : (32'd1 << rv_id[cyc]));
      if (rv_chk[cyc]) chk("rnd_rdata", {28'b0, bus.rdata}, {28'b0, rv_dat[cyc]});
      if (w >= 0) begin
        e_en = 1'b1;
        e_we = pwe[w];
        e_addr = pa[w];
        e_di = pd[w];
        if (pwe[w]) begin
          ref_mem[pa[w][2:0]] = pd[w];
          ref_known[pa[w][2:0]] = 1'b1;
        end else begin
          rv_id[cyc + 2]  = w;
          rv_chk[cyc + 2] = ref_known[pa[w][2:0]];
          rv_dat[cyc + 2] = ref_mem[pa[w][2:0]];
        end
        pend[w] = 1'b0;
        ptr = (w + 1) % 2;
      end else begin
        e_en = 1'b0;
        e_we = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
